arp_udp_rx_demux: RTL and testbench
===================================

Name: arp_udp_rx_demux

Overview:
Receive-side counterpart of the ARP/UDP transmit arbiter. It watches the single GMII receive byte stream, parses the preamble, destination MAC and EtherType of each frame, and steers the whole frame, preamble included, to either the ARP receiver or the UDP/IP receiver. Frames that match neither are dropped. It sits between the RGMII-to-GMII receive converter and the protocol receivers, so those receivers see an unmodified GMII stream delayed by a fixed 22 cycles.

Parameters:
BOARD_MAC, 48'h00_11_22_33_44_55, local MAC; accepted destination MAC alongside broadcast
MAC_FILTER_EN, 1, 1: drop frames whose DA is neither BOARD_MAC nor FF:FF:FF:FF:FF:FF; 0: accept any DA
CNT_W, 16, width of statistics counters

Ports:
gmii_rx_clk  input  1  receive clock, 125 MHz; sole clock
rst  input  1  synchronous active-high reset
gmii_rx_dv  input  1  receive data valid
gmii_rxd  input  8  receive data
arp_gmii_rx_dv  output  1  valid to ARP receiver
arp_gmii_rxd  output  8  data to ARP receiver
udp_gmii_rx_dv  output  1  valid to UDP receiver
udp_gmii_rxd  output  8  data to UDP receiver
arp_frame_cnt  output  CNT_W  frames routed to ARP, wraps
udp_frame_cnt  output  CNT_W  frames routed to UDP, wraps
drop_cnt  output  CNT_W  frames dropped, wraps

Behaviour:
- Reset: all outputs 0; delay line cleared (valid and SOF bits 0); counters 0; FSM goes to WAIT_END if gmii_rx_dv=1, otherwise IDLE.
- Delay line: HDR_LEN=22 stages. Each stage holds {valid, sof, byte}. The entry written on each cycle is {gmii_rx_dv, first byte of frame, gmii_rxd}.
- Output latency is exactly 22 cycles. The output data bus is always driven from the head of the line. Each dv output is head.valid AND route==that port.
- Input FSM states:
  - IDLE: on dv=1, set byte index 0 and go to HDR.
  - HDR: on each byte, increment the index and run the checks below. At index 21, with dv=1, go to BODY and issue the decision strobe. If dv=0 before index 21, the frame is a runt; go to IDLE.
  - BODY: on dv=0, go to IDLE.
  - WAIT_END: on dv=0, go to IDLE. Bytes arriving in this state enter the line with sof=0, so they are never routed.
- Header checks:
  - Indices 0–6 must be 0x55; index 7 must be 0xD5.
  - Indices 8–13 are the DA. With MAC_FILTER_EN=1, every byte must match broadcast or every byte must match BOARD_MAC.
  - Indices 20–21 are the EtherType. 0x0806 selects ARP, 0x0800 selects UDP, any other value selects DROP.
  - Any failed check forces the decision to DROP.
- Routing: the decision strobe fires in the same cycle the frame's SOF stage reaches the head of the line.
  - When a SOF stage reaches the head, latch route = decision if the strobe is active; otherwise route = DROP (runt case).
  - route holds until the next SOF reaches the head. Stages with valid=0 produce no output.
- Back-to-back frames: a minimum one-cycle dv-low gap is supported. Several frames may be in the line at once; the per-SOF latching keeps them separate.
- Counters: each counter increments once per SOF reaching the head, as ARP, UDP or DROP. A runt counts as a drop.
- Truncated frames: if dv falls mid-frame after the decision, the already-routed bytes are forwarded. The downstream CRC check rejects them.
- Reset mid-frame: the partially forwarded frame ends immediately with dv=0; no counter changes.

Decomposition:
- Shared package eth_pkg holds:
  - ETH_TYPE_ARP=16'h0806 and ETH_TYPE_IP=16'h0800
  - PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5
  - HDR_LEN=22
  - route enum {ROUTE_DROP, ROUTE_ARP, ROUTE_UDP}
- One sub-module, gmii_delay_line: a parameterised depth × {valid, sof, data} shift register with synchronous clear.

Test Plan:
- ARP request: 72-byte frame, DA broadcast, type 0806 -> arp_gmii_rx_dv high for cycles 22..93 with identical bytes; udp dv stays 0; arp_frame_cnt=1.
- UDP frame to BOARD_MAC, type 0800, 80 bytes -> udp dv high for 80 cycles starting 22 cycles after input; udp_frame_cnt=1.
- Wrong DA (00:AA:..), type 0800, MAC_FILTER_EN=1 -> both dv outputs 0; drop_cnt=1. Repeat with MAC_FILTER_EN=0 -> routed to UDP.
- Runt: 15-byte frame, then a 1-cycle gap, then a valid ARP frame -> runt is not forwarded, drop_cnt=1; ARP frame forwarded intact with correct 22-cycle alignment.
- Bad SFD (0xD4) or type 0x86DD -> dropped; drop_cnt increments once.
- Reset asserted at byte 40 of a UDP frame, while dv stays high -> outputs 0 the next cycle; the rest of that frame is ignored (WAIT_END); the next frame is routed normally.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet receive constants and the frame route encoding.
// No ports; imported by the demultiplexer and its delay line.
package eth_pkg;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          HDR_LEN       = 22;

    typedef enum logic [1:0] {ROUTE_DROP, ROUTE_ARP, ROUTE_UDP} route_t;

    function automatic route_t type_route(input logic [15:0] eth_type);
        return eth_type == ETH_TYPE_ARP ? ROUTE_ARP :
               eth_type == ETH_TYPE_IP  ? ROUTE_UDP : ROUTE_DROP;
    endfunction
endpackage

// File: rtl/gmii_delay_line.sv
// gmii_delay_line: fixed-depth shift register of {valid, sof, data} GMII stages.
// Ports: i_clk clock; i_clr synchronous clear of every stage;
//        i_valid/i_sof/i_data stage-0 entry; o_valid/o_sof/o_data head stage.
module gmii_delay_line #(
    parameter int DEPTH = 22
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_valid,
    input  logic       i_sof,
    input  logic [7:0] i_data,
    output logic       o_valid,
    output logic       o_sof,
    output logic [7:0] o_data
);
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_sof;
    logic [DEPTH-1:0][7:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_valid <= '0;
            r_sof   <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= {r_valid[DEPTH-2:0], i_valid};
            r_sof   <= {r_sof[DEPTH-2:0], i_sof};
            r_data  <= {r_data[DEPTH-2:0], i_data};
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_sof   = r_sof[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];
endmodule

// File: rtl/arp_udp_rx_demux.sv
// arp_udp_rx_demux: steers whole GMII receive frames to the ARP or UDP receiver.
// Ports: gmii_rx_clk/rst clock and sync reset; gmii_rx_dv/gmii_rxd input stream;
//        arp_*/udp_* the same stream delayed 22 cycles, valid only for its route;
//        arp_frame_cnt/udp_frame_cnt/drop_cnt wrapping per-frame statistics.
module arp_udp_rx_demux
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC     = 48'h00_11_22_33_44_55,
    parameter bit          MAC_FILTER_EN = 1'b1,
    parameter int          CNT_W         = 16
) (
    input  logic             gmii_rx_clk,
    input  logic             rst,
    input  logic             gmii_rx_dv,
    input  logic [7:0]       gmii_rxd,
    output logic             arp_gmii_rx_dv,
    output logic [7:0]       arp_gmii_rxd,
    output logic             udp_gmii_rx_dv,
    output logic [7:0]       udp_gmii_rxd,
    output logic [CNT_W-1:0] arp_frame_cnt,
    output logic [CNT_W-1:0] udp_frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HDR      = 2'd1;
    localparam logic [1:0] S_BODY     = 2'd2;
    localparam logic [1:0] S_WAIT_END = 2'd3;
    localparam logic [4:0] LAST_IDX   = 5'(HDR_LEN - 1);

    logic [1:0] r_state;
    logic [4:0] r_idx;
    logic       r_hdr_ok;
    logic       r_da_bcast;
    logic       r_da_board;
    logic [7:0] r_type_hi;
    logic       r_strobe;
    route_t     r_decision;
    route_t     r_route;

    logic       w_sof_in;
    logic       w_head_valid;
    logic       w_head_sof;
    logic [7:0] w_head_data;
    logic [7:0] w_mac_byte;
    logic       w_is_da;
    route_t     w_decision;
    route_t     w_route;

    assign w_sof_in = r_state == S_IDLE && gmii_rx_dv;

    gmii_delay_line #(.DEPTH(HDR_LEN)) u_line (
        .i_clk  (gmii_rx_clk),
        .i_clr  (rst),
        .i_valid(gmii_rx_dv),
        .i_sof  (w_sof_in),
        .i_data (gmii_rxd),
        .o_valid(w_head_valid),
        .o_sof  (w_head_sof),
        .o_data (w_head_data)
    );

    // DA byte n (index 8+n) is BOARD_MAC byte n counted from the MSB.
    assign w_mac_byte = 8'(BOARD_MAC >> {5'd13 - r_idx, 3'b000});
    assign w_is_da    = r_idx >= 5'd8 && r_idx <= 5'd13;
    // Evaluated on the last header byte, which is also the EtherType low byte.
    assign w_decision = r_hdr_ok && (!MAC_FILTER_EN || r_da_bcast || r_da_board) ?
                        type_route({r_type_hi, gmii_rxd}) : ROUTE_DROP;

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            r_state    <= gmii_rx_dv ? S_WAIT_END : S_IDLE;
            r_idx      <= '0;
            r_hdr_ok   <= 1'b0;
            r_da_bcast <= 1'b0;
            r_da_board <= 1'b0;
            r_type_hi  <= '0;
            r_strobe   <= 1'b0;
            r_decision <= ROUTE_DROP;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                S_IDLE: if (gmii_rx_dv) begin
                    r_state    <= S_HDR;
                    r_idx      <= 5'd1;
                    r_hdr_ok   <= gmii_rxd == PREAMBLE_BYTE;
                    r_da_bcast <= 1'b1;
                    r_da_board <= 1'b1;
                end
                S_HDR: if (!gmii_rx_dv) begin
                    r_state <= S_IDLE;
                end else begin
                    r_idx <= r_idx + 5'd1;
                    if (r_idx <= 5'd6) r_hdr_ok <= r_hdr_ok && gmii_rxd == PREAMBLE_BYTE;
                    if (r_idx == 5'd7) r_hdr_ok <= r_hdr_ok && gmii_rxd == SFD_BYTE;
                    if (w_is_da) begin
                        r_da_bcast <= r_da_bcast && gmii_rxd == 8'hFF;
                        r_da_board <= r_da_board && gmii_rxd == w_mac_byte;
                    end
                    if (r_idx == 5'd20) r_type_hi <= gmii_rxd;
                    if (r_idx == LAST_IDX) begin
                        r_state    <= S_BODY;
                        r_strobe   <= 1'b1;
                        r_decision <= w_decision;
                    end
                end
                default: if (!gmii_rx_dv) r_state <= S_IDLE;
            endcase
        end
    end

    // The strobe lands exactly when its own SOF is at the head; a SOF without
    // a strobe belongs to a runt that never completed its header.
    assign w_route = w_head_sof ? (r_strobe ? r_decision : ROUTE_DROP) : r_route;

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            r_route       <= ROUTE_DROP;
            arp_frame_cnt <= '0;
            udp_frame_cnt <= '0;
            drop_cnt      <= '0;
        end else begin
            r_route       <= w_route;
            arp_frame_cnt <= arp_frame_cnt + CNT_W'(w_head_sof && w_route == ROUTE_ARP);
            udp_frame_cnt <= udp_frame_cnt + CNT_W'(w_head_sof && w_route == ROUTE_UDP);
            drop_cnt      <= drop_cnt + CNT_W'(w_head_sof && w_route == ROUTE_DROP);
        end
    end

    assign arp_gmii_rx_dv = w_head_valid && w_route == ROUTE_ARP;
    assign udp_gmii_rx_dv = w_head_valid && w_route == ROUTE_UDP;
    assign arp_gmii_rxd   = w_head_data;
    assign udp_gmii_rxd   = w_head_data;
endmodule

// File: tb/tb_arp_udp_rx_demux.sv
// tb_arp_udp_rx_demux: randomized frame-level checks of both MAC filter settings.
`timescale 1ns/1ps
module tb_arp_udp_rx_demux;
    import eth_pkg::*;

    typedef logic [7:0] bq_t[$];

    localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER = 48'h00_AA_BB_CC_DD_EE;
    localparam int LAT = 22;
    localparam int N   = 8192;

    logic clk = 1'b0, rst = 1'b1, dv = 1'b0;
    logic [7:0] rxd = '0;
    logic a_dv, u_dv, na_dv, nu_dv;
    logic [7:0] a_d, u_d, na_d, nu_d;
    logic [15:0] a_cnt, u_cnt, d_cnt, na_cnt, nu_cnt, nd_cnt;

    int checks = 0, errors = 0, cyc = 0;
    route_t tag_f = ROUTE_DROP, tag_nf = ROUTE_DROP;
    logic in_dv[N];
    logic [7:0] in_d[N];
    logic in_rst[N];
    route_t in_tf[N], in_tnf[N];
    logic [35:0] obs[N];
    int exp_f[3], exp_nf[3];

    arp_udp_rx_demux #(.BOARD_MAC(MAC), .MAC_FILTER_EN(1'b1), .CNT_W(16)) dut (
        .gmii_rx_clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rxd(rxd),
        .arp_gmii_rx_dv(a_dv), .arp_gmii_rxd(a_d), .udp_gmii_rx_dv(u_dv), .udp_gmii_rxd(u_d),
        .arp_frame_cnt(a_cnt), .udp_frame_cnt(u_cnt), .drop_cnt(d_cnt));

    arp_udp_rx_demux #(.BOARD_MAC(MAC), .MAC_FILTER_EN(1'b0), .CNT_W(16)) dut_nf (
        .gmii_rx_clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rxd(rxd),
        .arp_gmii_rx_dv(na_dv), .arp_gmii_rxd(na_d), .udp_gmii_rx_dv(nu_dv), .udp_gmii_rxd(nu_d),
        .arp_frame_cnt(na_cnt), .udp_frame_cnt(nu_cnt), .drop_cnt(nd_cnt));

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < N) begin
            in_dv[cyc]  = dv;
            in_d[cyc]   = rxd;
            in_rst[cyc] = rst;
            in_tf[cyc]  = tag_f;
            in_tnf[cyc] = tag_nf;
            obs[cyc]    = {a_dv, u_dv, na_dv, nu_dv, a_d, u_d, na_d, nu_d};
        end
    end

    // Frame-level routing decision derived from the byte list alone.
    function automatic route_t classify(input bq_t f, input bit filt);
        logic [47:0] da;
        logic [15:0] t;
        if (f.size() < 22) return ROUTE_DROP;
        for (int i = 0; i < 7; i++) if (f[i] != 8'h55) return ROUTE_DROP;
        if (f[7] != 8'hD5) return ROUTE_DROP;
        da = {f[8], f[9], f[10], f[11], f[12], f[13]};
        t  = {f[20], f[21]};
        if (filt && da != MAC && da != BCAST) return ROUTE_DROP;
        return t == 16'h0806 ? ROUTE_ARP : t == 16'h0800 ? ROUTE_UDP : ROUTE_DROP;
    endfunction

    function automatic bq_t make_frame(input logic [47:0] da, input logic [15:0] t,
                                       input int len, input logic [7:0] sfd);
        bq_t f;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(sfd);
        for (int i = 5; i >= 0; i--) f.push_back(da[8*i +: 8]);
        for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
        f.push_back(t[15:8]);
        f.push_back(t[7:0]);
        while (f.size() < len) f.push_back(8'($urandom));
        while (f.size() > len) f.pop_back();
        return f;
    endfunction

    // Output expected at cycle n: the input of n-22, unless a reset hit it in flight.
    function automatic logic [35:0] expect_at(input int n);
        int m = n - LAT;
        if (m < 0) return '0;
        for (int k = m; k < n; k++) if (in_rst[k]) return '0;
        return {in_dv[m] && in_tf[m] == ROUTE_ARP, in_dv[m] && in_tf[m] == ROUTE_UDP,
                in_dv[m] && in_tnf[m] == ROUTE_ARP, in_dv[m] && in_tnf[m] == ROUTE_UDP,
                {4{in_d[m]}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bq_t f, input int gap);
        route_t rf = classify(f, 1'b1);
        route_t rn = classify(f, 1'b0);
        exp_f[rf]++;
        exp_nf[rn]++;
        for (int i = 0; i < f.size(); i++) begin
            tag_f = rf; tag_nf = rn; dv = 1'b1; rxd = f[i];
            tick();
        end
        dv = 1'b0; rxd = '0; tag_f = ROUTE_DROP; tag_nf = ROUTE_DROP;
        repeat (gap) tick();
    endtask

    task automatic drain();
        repeat (LAT + 4) tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({a_dv, u_dv, na_dv, nu_dv, a_d, u_d, na_d, nu_d} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", {a_dv, u_dv, na_dv, nu_dv, a_d, u_d, na_d, nu_d});
        end
        checks++;
        if ({a_cnt, u_cnt, d_cnt, na_cnt, nu_cnt, nd_cnt} !== 96'h0) begin
            errors++;
            $display("FAIL reset_counters got %h expected 0", {a_cnt, u_cnt, d_cnt, na_cnt, nu_cnt, nd_cnt});
        end
    endtask

    task automatic test_arp();
        int t0 = cyc, first = -1, cnt = 0;
        send_frame(make_frame(BCAST, 16'h0806, 72, 8'hD5), 1);
        drain();
        for (int n = t0; n < cyc; n++) begin
            if (obs[n][35] && first < 0) first = n - t0;
            cnt += int'(obs[n][35]);
            checks++;
            if (obs[n] !== expect_at(n)) begin
                errors++;
                $display("FAIL arp_stream cyc %0d got %h expected %h", n, obs[n], expect_at(n));
            end
        end
        checks++;
        if (first != 22 || cnt != 72) begin
            errors++;
            $display("FAIL arp_window got start %0d len %0d expected start 22 len 72", first, cnt);
        end
        checks++;
        if ({a_cnt, u_cnt, d_cnt} !== {16'(exp_f[ROUTE_ARP]), 16'(exp_f[ROUTE_UDP]), 16'(exp_f[ROUTE_DROP])}) begin
            errors++;
            $display("FAIL arp_counters got %0d/%0d/%0d expected %0d/%0d/%0d", a_cnt, u_cnt, d_cnt,
                     exp_f[ROUTE_ARP], exp_f[ROUTE_UDP], exp_f[ROUTE_DROP]);
        end
    endtask

    task automatic test_udp();
        int t0 = cyc, first = -1, cnt = 0;
        send_frame(make_frame(MAC, 16'h0800, 80, 8'hD5), 1);
        drain();
        for (int n = t0; n < cyc; n++) begin
            if (obs[n][34] && first < 0) first = n - t0;
            cnt += int'(obs[n][34]);
            checks++;
            if (obs[n] !== expect_at(n)) begin
                errors++;
                $display("FAIL udp_stream cyc %0d got %h expected %h", n, obs[n], expect_at(n));
            end
        end
        checks++;
        if (first != 22 || cnt != 80) begin
            errors++;
            $display("FAIL udp_window got start %0d len %0d expected start 22 len 80", first, cnt);
        end
        checks++;
        if ({a_cnt, u_cnt, d_cnt} !== {16'(exp_f[ROUTE_ARP]), 16'(exp_f[ROUTE_UDP]), 16'(exp_f[ROUTE_DROP])}) begin
            errors++;
            $display("FAIL udp_counters got %0d/%0d/%0d expected %0d/%0d/%0d", a_cnt, u_cnt, d_cnt,
                     exp_f[ROUTE_ARP], exp_f[ROUTE_UDP], exp_f[ROUTE_DROP]);
        end
    endtask

    task automatic test_mac_filter();
        int t0 = cyc;
        logic [15:0] d0 = d_cnt, nu0 = nu_cnt;
        send_frame(make_frame(OTHER, 16'h0800, 64, 8'hD5), 1);
        drain();
        for (int n = t0; n < cyc; n++) begin
            checks++;
            if (obs[n] !== expect_at(n)) begin
                errors++;
                $display("FAIL filter_stream cyc %0d got %h expected %h", n, obs[n], expect_at(n));
            end
        end
        checks++;
        if (d_cnt - d0 !== 16'd1 || nu_cnt - nu0 !== 16'd1) begin
            errors++;
            $display("FAIL filter_counts got drop+%0d nofilter_udp+%0d expected drop+1 nofilter_udp+1",
                     d_cnt - d0, nu_cnt - nu0);
        end
    endtask

    task automatic test_runt_back_to_back();
        int t0 = cyc, first = -1, cnt = 0;
        logic [15:0] d0 = d_cnt;
        send_frame(make_frame(BCAST, 16'h0806, 15, 8'hD5), 1);
        send_frame(make_frame(BCAST, 16'h0806, 72, 8'hD5), 1);
        drain();
        for (int n = t0; n < cyc; n++) begin
            if (obs[n][35] && first < 0) first = n - t0;
            cnt += int'(obs[n][35]);
            checks++;
            if (obs[n] !== expect_at(n)) begin
                errors++;
                $display("FAIL runt_stream cyc %0d got %h expected %h", n, obs[n], expect_at(n));
            end
        end
        checks++;
        if (first != 38 || cnt != 72 || d_cnt - d0 !== 16'd1) begin
            errors++;
            $display("FAIL runt_b2b got start %0d len %0d drop+%0d expected start 38 len 72 drop+1",
                     first, cnt, d_cnt - d0);
        end
    endtask

    task automatic test_bad_header();
        int t0 = cyc;
        logic [15:0] d0 = d_cnt, a0 = a_cnt;
        send_frame(make_frame(BCAST, 16'h0806, 60, 8'hD4), 1);
        send_frame(make_frame(MAC, 16'h86DD, 70, 8'hD5), 2);
        drain();
        for (int n = t0; n < cyc; n++) begin
            checks++;
            if (obs[n] !== expect_at(n)) begin
                errors++;
                $display("FAIL badhdr_stream cyc %0d got %h expected %h", n, obs[n], expect_at(n));
            end
        end
        checks++;
        if (d_cnt - d0 !== 16'd2 || a_cnt !== a0) begin
            errors++;
            $display("FAIL badhdr_counts got drop+%0d arp+%0d expected drop+2 arp+0", d_cnt - d0, a_cnt - a0);
        end
    endtask

    task automatic test_reset_midframe();
        int t0 = cyc;
        bq_t f = make_frame(MAC, 16'h0800, 80, 8'hD5);
        route_t rf = classify(f, 1'b1);
        route_t rn = classify(f, 1'b0);
        exp_f[rf]++;
        exp_nf[rn]++;
        for (int i = 0; i < f.size(); i++) begin
            rst = i == 40;
            if (i == 40) begin
                exp_f = '{0, 0, 0};
                exp_nf = '{0, 0, 0};
            end
            tag_f = i >= 40 ? ROUTE_DROP : rf;
            tag_nf = i >= 40 ? ROUTE_DROP : rn;
            dv = 1'b1; rxd = f[i];
            tick();
        end
        rst = 1'b0; dv = 1'b0; rxd = '0; tag_f = ROUTE_DROP; tag_nf = ROUTE_DROP;
        tick();
        send_frame(make_frame(BCAST, 16'h0806, 64, 8'hD5), 1);
        drain();
        for (int n = t0; n < cyc; n++) begin
            checks++;
            if (obs[n] !== expect_at(n)) begin
                errors++;
                $display("FAIL rstmid_stream cyc %0d got %h expected %h", n, obs[n], expect_at(n));
            end
        end
        checks++;
        if (obs[t0+40][34] !== 1'b1 || obs[t0+41][35:32] !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_cut got dv %b then %b expected udp high then 0000",
                     obs[t0+40][35:32], obs[t0+41][35:32]);
        end
        checks++;
        if ({a_cnt, u_cnt, d_cnt, na_cnt, nu_cnt, nd_cnt} !== {16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL rstmid_counters got %0d/%0d/%0d %0d/%0d/%0d expected 1/0/0 1/0/0",
                     a_cnt, u_cnt, d_cnt, na_cnt, nu_cnt, nd_cnt);
        end
    endtask

    task automatic test_random();
        int t0 = cyc;
        logic [47:0] das[3] = '{BCAST, MAC, 48'h02_13_57_9B_DF_01};
        logic [15:0] types[3] = '{16'h0806, 16'h0800, 16'h86DD};
        for (int k = 0; k < 14; k++)
            send_frame(make_frame(das[$urandom_range(0, 2)], types[$urandom_range(0, 2)],
                                  int'($urandom_range(12, 90)),
                                  $urandom_range(0, 7) == 0 ? 8'hD4 : 8'hD5),
                       int'($urandom_range(1, 4)));
        drain();
        for (int n = t0; n < cyc; n++) begin
            checks++;
            if (obs[n] !== expect_at(n)) begin
                errors++;
                $display("FAIL random_stream cyc %0d got %h expected %h", n, obs[n], expect_at(n));
            end
        end
        checks++;
        if ({a_cnt, u_cnt, d_cnt, na_cnt, nu_cnt, nd_cnt} !==
            {16'(exp_f[ROUTE_ARP]), 16'(exp_f[ROUTE_UDP]), 16'(exp_f[ROUTE_DROP]),
             16'(exp_nf[ROUTE_ARP]), 16'(exp_nf[ROUTE_UDP]), 16'(exp_nf[ROUTE_DROP])}) begin
            errors++;
            $display("FAIL random_counters got %0d/%0d/%0d %0d/%0d/%0d expected %0d/%0d/%0d %0d/%0d/%0d",
                     a_cnt, u_cnt, d_cnt, na_cnt, nu_cnt, nd_cnt,
                     exp_f[ROUTE_ARP], exp_f[ROUTE_UDP], exp_f[ROUTE_DROP],
                     exp_nf[ROUTE_ARP], exp_nf[ROUTE_UDP], exp_nf[ROUTE_DROP]);
        end
    endtask

    initial begin
        exp_f = '{0, 0, 0};
        exp_nf = '{0, 0, 0};
        repeat (5) tick();
        rst = 1'b0;
        test_reset();
        test_arp();
        test_udp();
        test_mac_filter();
        test_runt_back_to_back();
        test_bad_header();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
